// File: rtl/secs_ones_counter.sv
// rtl/secs_ones_counter.sv - seconds-units BCD countdown stage with prescaler, borrow and expiry detection
module secs_ones_counter #(
    parameter int PRESCALE = 4,
    parameter int PW       = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       en,
    input  logic       upper_zero,
    output logic [3:0] ones,
    output logic       tc,
    output logic       zero,
    output logic       tick,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    state_t        state;
    logic [PW-1:0] prescaler;

    assign zero = (ones == 4'd0);
    assign tick = (state == RUN) && en && (prescaler == LAST);
    assign tc   = tick && zero && !upper_zero;

    always_ff @(posedge clk) begin
        if (clr) begin
            ones      <= 4'd0;
            prescaler <= '0;
            state     <= IDLE;
            done      <= 1'b0;
        end else if (!loadn) begin
            ones      <= (data > 4'd9) ? 4'd9 : data;
            prescaler <= '0;
            state     <= IDLE;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && zero && upper_zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Pausing keeps the prescaler so a resumed second is not restarted.
                    if (!en) begin
                        state <= IDLE;
                    end else if (prescaler != LAST) begin
                        prescaler <= prescaler + 1'b1;
                    end else begin
                        prescaler <= '0;
                        if (!zero) begin
                            ones <= ones - 4'd1;
                            if (ones == 4'd1 && upper_zero) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else if (!upper_zero) begin
                            ones <= 4'd9;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
